mem_req_ctrl: RTL and testbench
===============================

Name: mem_req_ctrl

Overview:
Request/hold adapter between the pipeline memory stage and the two-way cached memory system (mem_system). Latches a pipeline load or store and presents it to mem_system, holding it stable until Done. It stalls the pipeline while the access is outstanding and returns load data. It also flags misaligned and failed or timed-out accesses, and keeps access/hit performance counters.

Parameters:
CNT_W, 16, width of the saturating access and hit counters
TIMEOUT, 63, max cycles in BUSY without Done before a timeout error (must be >=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
pipe_rd  input  1  memory stage requests a load
pipe_wr  input  1  memory stage requests a store (pipe_rd and pipe_wr both high is treated as a store)
pipe_addr  input  16  byte address of the access
pipe_wdata  input  16  store data
pipe_rdata  output  16  load data, valid when pipe_stall=0 in the RESP cycle
pipe_stall  output  1  hold the memory stage and everything upstream
align_err  output  1  combinational, pipe_addr[0]=1 on a request in IDLE
mem_fault  output  1  sticky, mem_system err seen or timeout expired
Addr  output  16  to mem_system
DataIn  output  16  to mem_system
Rd  output  1  to mem_system
Wr  output  1  to mem_system
DataOut  input  16  from mem_system
Done  input  1  from mem_system, completes the current access
Stall  input  1  from mem_system, informational only
CacheHit  input  1  from mem_system, qualified by Done
err  input  1  from mem_system
acc_cnt  output  CNT_W  completed accesses, saturating
hit_cnt  output  CNT_W  completed accesses with CacheHit=1, saturating

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst). All state is cleared immediately on rst.
- Reset values:
  - state=IDLE.
  - Addr, DataIn, pipe_rdata, acc_cnt, hit_cnt = 0.
  - Rd, Wr, pipe_stall, mem_fault = 0.
  - Timeout counter = 0.
- States: IDLE, BUSY, RESP, FAULT (2-bit encoding).
- IDLE:
  - req = pipe_rd|pipe_wr.
  - req with pipe_addr[0]=1: align_err=1 and pipe_stall=0; no memory access; stay in IDLE.
  - req aligned: pipe_stall=1 in the same cycle (combinational). At the edge, latch Addr<=pipe_addr, DataIn<=pipe_wdata, Wr<=pipe_wr, Rd<=pipe_rd&~pipe_wr, clear the timeout counter, and go to BUSY.
- BUSY:
  - Rd/Wr and Addr/DataIn are held constant from registers. pipe_stall=1.
  - Done=1 (may occur in the first BUSY cycle):
    - pipe_rdata<=DataOut if Rd, else unchanged.
    - acc_cnt+1 and, if CacheHit, hit_cnt+1; each saturates at all-ones.
    - Rd<=0, Wr<=0; go to RESP.
  - err=1 (takes priority over Done in the same cycle): Rd<=0, Wr<=0, mem_fault<=1, go to FAULT; counters unchanged.
  - Otherwise the timeout counter increments. If it equals TIMEOUT-1 while Done=0, take the fault path above.
- RESP (exactly 1 cycle):
  - pipe_stall=0; pipe_rdata is valid.
  - The pipeline advances at this edge. The still-present request is consumed, not reissued.
  - Next state is IDLE unconditionally.
- FAULT: terminal until rst. pipe_stall=1, Rd=Wr=0, mem_fault=1.
- align_err is 0 in every state except IDLE.
- Rd and Wr are never both 1, and are deasserted the cycle after Done.
- Changes on the pipe_* inputs during BUSY, RESP or FAULT are ignored.
- rst mid-access: return to IDLE immediately. Rd/Wr drop asynchronously; no completion is counted.
- Back-to-back accesses: minimum 3 cycles per access (IDLE issue, BUSY with Done, RESP).

Test Plan:
- Aligned load of 0x0010 with the mem model returning DataOut=0xBEEF, CacheHit=1, Done in the first BUSY cycle. Required: Rd high for exactly 1 cycle, pipe_stall high for 2 cycles, pipe_rdata=0xBEEF in RESP, acc_cnt=1, hit_cnt=1.
- Store 0x1234 to 0x0022 with Done after 5 BUSY cycles and CacheHit=0. Required: Wr, Addr=0x0022 and DataIn=0x1234 stable for all 5 cycles, pipe_rdata unchanged, acc_cnt=1, hit_cnt=0.
- pipe_rd with pipe_addr=0x0013. Required: align_err=1 the same cycle, pipe_stall=0, Rd/Wr stay 0, counters unchanged.
- err=1 and Done=1 together in BUSY. Required: go to FAULT, mem_fault=1, pipe_stall stuck at 1, acc_cnt unchanged; then rst recovers to IDLE with all outputs 0.
- TIMEOUT=4 and Done never arrives. Required: FAULT entered after 4 BUSY cycles with mem_fault=1.
- Force acc_cnt to 0xFFFF and complete one more access. Required: acc_cnt stays 0xFFFF. Separately, assert rst mid-BUSY: Rd drops with no clock edge.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// Pipeline-to-mem_system request holder: latches one access, holds Rd/Wr/Addr/DataIn until Done.
// Latency: issue + BUSY (>=1 cycle) + 1 RESP cycle; pipe_stall backpressures the pipeline throughout.
module mem_req_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_rd,
    input  logic             pipe_wr,
    input  logic [15:0]      pipe_addr,
    input  logic [15:0]      pipe_wdata,
    output logic [15:0]      pipe_rdata,
    output logic             pipe_stall,
    output logic             align_err,
    output logic             mem_fault,
    output logic [15:0]      Addr,
    output logic [15:0]      DataIn,
    output logic             Rd,
    output logic             Wr,
    input  logic [15:0]      DataOut,
    input  logic             Done,
    input  logic             Stall,
    input  logic             CacheHit,
    input  logic             err,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_RESP  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_addr;
    logic [15:0]      r_din;
    logic [15:0]      r_rdata;
    logic             r_rd;
    logic             r_wr;
    logic             r_fault;
    logic [TW-1:0]    r_tcnt;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_hit;
    logic             w_req;
    logic             w_issue;
    logic             w_complete;
    logic             w_fault;
    logic             w_unused;

    assign w_req    = pipe_rd | pipe_wr;
    assign w_unused = Stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        pipe_stall = 1'b0;
        align_err  = 1'b0;
        w_issue    = 1'b0;
        w_complete = 1'b0;
        w_fault    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (pipe_addr[0]) begin
                        align_err = 1'b1;
                    end else begin
                        pipe_stall = 1'b1;
                        w_issue    = 1'b1;
                        w_next     = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                pipe_stall = 1'b1;
                // err wins over a coincident Done; timeout only fires when Done is absent
                if (err || (!Done && r_tcnt == TLAST)) begin
                    w_fault = 1'b1;
                    w_next  = S_FAULT;
                end else if (Done) begin
                    w_complete = 1'b1;
                    w_next     = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: pipe_stall = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_din   <= '0;
            r_rdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_fault <= 1'b0;
            r_tcnt  <= '0;
            r_acc   <= '0;
            r_hit   <= '0;
        end else begin
            if (w_issue) begin
                r_addr <= pipe_addr;
                r_din  <= pipe_wdata;
                r_wr   <= pipe_wr;
                r_rd   <= pipe_rd & ~pipe_wr;
                r_tcnt <= '0;
            end
            if (w_complete) begin
                if (r_rd) r_rdata <= DataOut;
                if (r_acc != '1) r_acc <= r_acc + CNT_W'(1);
                if (CacheHit && r_hit != '1) r_hit <= r_hit + CNT_W'(1);
                r_rd <= 1'b0;
                r_wr <= 1'b0;
            end
            if (w_fault) begin
                r_rd    <= 1'b0;
                r_wr    <= 1'b0;
                r_fault <= 1'b1;
            end
            if (r_state == S_BUSY && !w_complete && !w_fault) r_tcnt <= r_tcnt + TW'(1);
        end
    end

    assign Addr       = r_addr;
    assign DataIn     = r_din;
    assign Rd         = r_rd;
    assign Wr         = r_wr;
    assign pipe_rdata = r_rdata;
    assign mem_fault  = r_fault;
    assign acc_cnt    = r_acc;
    assign hit_cnt    = r_hit;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: directed table, random transactions vs. a counting model, and a
// small-parameter instance for counter saturation and the Done timeout.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_rd = 1'b0, pipe_wr = 1'b0;
    logic [15:0] pipe_addr = '0, pipe_wdata = '0;
    logic [15:0] pipe_rdata, Addr, DataIn;
    logic        pipe_stall, align_err, mem_fault, Rd, Wr;
    logic [15:0] DataOut = '0;
    logic        Done = 1'b0, Stall = 1'b0, CacheHit = 1'b0, err = 1'b0;
    logic [15:0] acc_cnt, hit_cnt;

    logic        rst2 = 1'b1, rd2 = 1'b0, done2 = 1'b0, hit2 = 1'b1, zero = 1'b0;
    logic [15:0] addr2 = '0;
    logic [15:0] a_rdata, a_addr, a_din;
    logic        a_stall, a_align, a_fault, a_rd, a_wr;
    logic [1:0]  a_acc, a_hit;

    int n_chk = 0;
    int n_err = 0;
    int m_acc = 0, m_hit = 0;
    logic [15:0] m_rdata = '0;

    always #5 clk = ~clk;

    mem_req_ctrl dut (
        .clk(clk), .rst(rst), .pipe_rd(pipe_rd), .pipe_wr(pipe_wr),
        .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata),
        .pipe_stall(pipe_stall), .align_err(align_err), .mem_fault(mem_fault),
        .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr), .DataOut(DataOut),
        .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .acc_cnt(acc_cnt), .hit_cnt(hit_cnt)
    );

    mem_req_ctrl #(.CNT_W(2), .TIMEOUT(4)) u_aux (
        .clk(clk), .rst(rst2), .pipe_rd(rd2), .pipe_wr(zero),
        .pipe_addr(addr2), .pipe_wdata(pipe_wdata), .pipe_rdata(a_rdata),
        .pipe_stall(a_stall), .align_err(a_align), .mem_fault(a_fault),
        .Addr(a_addr), .DataIn(a_din), .Rd(a_rd), .Wr(a_wr), .DataOut(DataOut),
        .Done(done2), .Stall(Stall), .CacheHit(hit2), .err(zero),
        .acc_cnt(a_acc), .hit_cnt(a_hit)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic        hit;
        logic [15:0] dout;
        logic        inj;
        logic [15:0] e_rdata;
        int          e_acc;
        int          e_hit;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_zero();
        chk("rst_rd", 32'(Rd), 0);
        chk("rst_wr", 32'(Wr), 0);
        chk("rst_stall", 32'(pipe_stall), 0);
        chk("rst_fault", 32'(mem_fault), 0);
        chk("rst_acc", 32'(acc_cnt), 0);
        chk("rst_hit", 32'(hit_cnt), 0);
        chk("rst_rdata", 32'(pipe_rdata), 0);
        chk("rst_addr", 32'(Addr), 0);
        chk("rst_din", 32'(DataIn), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pipe_rd = 1'b0; pipe_wr = 1'b0; Done = 1'b0; err = 1'b0;
        rst = 1'b1;
        #1;
        check_idle_zero();
        @(negedge clk);
        rst = 1'b0;
        m_acc = 0; m_hit = 0; m_rdata = '0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int lat, input logic hit,
                          input logic [15:0] dout, input logic inj,
                          input logic [15:0] e_rdata, input int e_acc, input int e_hit);
        @(negedge clk);
        pipe_rd = rd; pipe_wr = wr; pipe_addr = addr; pipe_wdata = wdata;
        Done = 1'b0; err = 1'b0;
        #1;
        if (addr[0]) begin
            chk("mis_align_err", 32'(align_err), 1);
            chk("mis_stall", 32'(pipe_stall), 0);
            @(negedge clk);
            pipe_rd = 1'b0; pipe_wr = 1'b0;
            #1;
            chk("mis_rd", 32'(Rd), 0);
            chk("mis_wr", 32'(Wr), 0);
            chk("mis_idle", 32'(pipe_stall), 0);
            chk("mis_acc", 32'(acc_cnt), 32'(e_acc));
            chk("mis_hit", 32'(hit_cnt), 32'(e_hit));
            return;
        end
        chk("issue_stall", 32'(pipe_stall), 1);
        chk("issue_align", 32'(align_err), 0);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            pipe_rd = 1'($urandom); pipe_wr = 1'($urandom);
            pipe_addr = 16'($urandom); pipe_wdata = 16'($urandom);
            Done = (i == lat); err = inj && (i == lat);
            CacheHit = hit; DataOut = dout;
            #1;
            chk("busy_rd", 32'(Rd), 32'(rd & ~wr));
            chk("busy_wr", 32'(Wr), 32'(wr));
            chk("busy_addr", 32'(Addr), 32'(addr));
            chk("busy_din", 32'(DataIn), 32'(wdata));
            chk("busy_stall", 32'(pipe_stall), 1);
            chk("busy_align", 32'(align_err), 0);
            chk("busy_fault", 32'(mem_fault), 0);
        end
        @(negedge clk);
        Done = 1'b0; err = 1'b0; DataOut = 16'($urandom);
        pipe_rd = rd; pipe_wr = wr; pipe_addr = addr;
        #1;
        if (inj) begin
            chk("fault_stall", 32'(pipe_stall), 1);
            chk("fault_rd", 32'(Rd), 0);
            chk("fault_wr", 32'(Wr), 0);
            chk("fault_flag", 32'(mem_fault), 1);
            chk("fault_acc", 32'(acc_cnt), 32'(e_acc));
            chk("fault_hit", 32'(hit_cnt), 32'(e_hit));
            @(negedge clk);
            #1;
            chk("fault_stuck", 32'(pipe_stall), 1);
            do_reset();
        end else begin
            chk("resp_stall", 32'(pipe_stall), 0);
            chk("resp_rd", 32'(Rd), 0);
            chk("resp_wr", 32'(Wr), 0);
            chk("resp_align", 32'(align_err), 0);
            chk("resp_rdata", 32'(pipe_rdata), 32'(e_rdata));
            chk("resp_acc", 32'(acc_cnt), 32'(e_acc));
            chk("resp_hit", 32'(hit_cnt), 32'(e_hit));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // rd wr addr wdata lat hit dout inj | rdata acc hit (cumulative from reset)
        tbl[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1, 1'b1, 16'hBEEF, 1'b0, 16'hBEEF, 1, 1};
        tbl[1] = '{1'b0, 1'b1, 16'h0022, 16'h1234, 5, 1'b0, 16'h9999, 1'b0, 16'hBEEF, 2, 1};
        tbl[2] = '{1'b1, 1'b0, 16'h0013, 16'h0000, 1, 1'b1, 16'h1111, 1'b0, 16'hBEEF, 2, 1};
        tbl[3] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 3, 1'b0, 16'h5A5A, 1'b0, 16'h5A5A, 3, 1};
        tbl[4] = '{1'b1, 1'b1, 16'h0040, 16'h7777, 2, 1'b1, 16'hDEAD, 1'b0, 16'h5A5A, 4, 2};
        tbl[5] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 2, 1'b1, 16'h4321, 1'b1, 16'h5A5A, 4, 2};

        #1;
        check_idle_zero();
        chk("rst_align", 32'(align_err), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 6; k++)
            access(tbl[k].rd, tbl[k].wr, tbl[k].addr, tbl[k].wdata, tbl[k].lat, tbl[k].hit,
                   tbl[k].dout, tbl[k].inj, tbl[k].e_rdata, tbl[k].e_acc, tbl[k].e_hit);

        // reset while an access is outstanding: Rd must fall without a clock edge
        @(negedge clk);
        pipe_rd = 1'b1; pipe_wr = 1'b0; pipe_addr = 16'h0200; Done = 1'b0;
        @(negedge clk);
        pipe_rd = 1'b0;
        #1;
        chk("midrst_rd_before", 32'(Rd), 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_rd_async", 32'(Rd), 0);
        chk("midrst_stall", 32'(pipe_stall), 0);
        chk("midrst_acc", 32'(acc_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_idle", 32'(pipe_stall), 0);

        for (int t = 0; t < 200; t++) begin
            logic        rd, wr, hit, inj;
            logic [15:0] addr, wdata, dout;
            int          lat, kind, op;
            kind = $urandom_range(0, 15);
            op   = $urandom_range(0, 2);
            rd   = (op != 1);
            wr   = (op != 0);
            inj  = (kind == 0);
            addr = 16'($urandom) & 16'hFFFE;
            if (kind == 1 || kind == 2) addr = addr | 16'h0001;
            wdata = 16'($urandom);
            dout  = 16'($urandom);
            hit   = 1'($urandom);
            lat   = $urandom_range(1, 6);
            if (!addr[0] && !inj) begin
                m_acc = (m_acc < 65535) ? m_acc + 1 : 65535;
                if (hit) m_hit = (m_hit < 65535) ? m_hit + 1 : 65535;
                if (rd && !wr) m_rdata = dout;
            end
            access(rd, wr, addr, wdata, lat, hit, dout, inj, m_rdata, m_acc, m_hit);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                pipe_rd = 1'b0; pipe_wr = 1'b0;
                #1;
                chk("gap_idle", 32'(pipe_stall), 0);
            end
        end

        // small-counter instance: saturation at all-ones, then Done timeout
        @(negedge clk);
        rst2 = 1'b0; addr2 = 16'h0008;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            rd2 = 1'b1; done2 = 1'b0;
            #1;
            chk("aux_issue_stall", 32'(a_stall), 1);
            @(negedge clk);
            rd2 = 1'b0; done2 = 1'b1;
            @(negedge clk);
            done2 = 1'b0;
            #1;
            chk("sat_acc", 32'(a_acc), 32'((n < 3) ? n : 3));
            chk("sat_hit", 32'(a_hit), 32'((n < 3) ? n : 3));
        end
        @(negedge clk);
        rd2 = 1'b1; done2 = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            rd2 = 1'b0;
            #1;
            chk("to_busy_rd", 32'(a_rd), 1);
            chk("to_busy_fault", 32'(a_fault), 0);
        end
        @(negedge clk);
        #1;
        chk("to_fault", 32'(a_fault), 1);
        chk("to_rd", 32'(a_rd), 0);
        chk("to_stall", 32'(a_stall), 1);
        chk("to_acc", 32'(a_acc), 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
